// File: rtl/rv_pkg.sv
// Shared RV32 core definitions: datapath width, fetch state encoding and reset constants.
package rv_pkg;

   localparam int XLEN = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_HOLD
   } fetch_state_t;

endpackage

// File: rtl/rv_fetch_unit.sv
// Instruction fetch stage: one outstanding read to the memory controller at a time,
// returned word is held for decode on a valid/ready handshake; redirects squash stale fetches.
module rv_fetch_unit #(
   parameter int ADDR_W = 24,
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [XLEN-1:0]   instr_data,
   output logic [XLEN-1:0]   instr_pc,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_data_in,
   output logic              mem_enable,
   input  logic [31:0]       mem_data_out,
   input  logic              mem_op_r
);

   import rv_pkg::*;

   fetch_state_t state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic discard, discard_nxt;
   logic capture;
   logic unused_redirect_bits;

   assign unused_redirect_bits = ^redirect_pc[1:0];

   assign mem_we      = 1'b0;
   assign mem_data_in = 32'h0;
   assign mem_enable  = (state == ST_REQ);
   assign instr_valid = (state == ST_HOLD);

   // A response that coincides with a redirect belongs to the old path, so it is
   // dropped and the outstanding request is considered retired (discard stays clear).
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      discard_nxt = discard;
      capture     = 1'b0;
      case (state)
         ST_IDLE: state_nxt = ST_REQ;
         ST_REQ: begin
            state_nxt = ST_WAIT;
            if (redirect_valid) discard_nxt = 1'b1;
         end
         ST_WAIT: begin
            if (mem_op_r) begin
               if (discard || redirect_valid) begin
                  state_nxt   = ST_REQ;
                  discard_nxt = 1'b0;
               end else begin
                  state_nxt = ST_HOLD;
                  capture   = 1'b1;
               end
            end else if (redirect_valid) begin
               discard_nxt = 1'b1;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               state_nxt = ST_REQ;
            end else if (instr_ready) begin
               state_nxt = ST_REQ;
               pc_nxt    = pc + XLEN'(4);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (redirect_valid) pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         pc      <= RESET_PC;
         discard <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         discard <= discard_nxt;
      end
   end

   // The address is loaded on entry to REQ so it stays put across the whole WAIT,
   // even if a redirect moves the PC underneath an outstanding request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr   <= '0;
         instr_data <= '0;
         instr_pc   <= '0;
      end else begin
         if (state_nxt == ST_REQ) mem_addr <= pc_nxt[ADDR_W+1:2];
         if (capture) begin
            instr_data <= mem_data_out;
            instr_pc   <= pc;
         end
      end
   end

endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
- Instruction fetch stage of the RV32 core, directly upstream of memory_controller_module.
- Holds the PC and issues one read per instruction to the memory controller: a one-cycle enable pulse with the word address, then waits for op_r.
- Captures the returned word and presents it to decode over a valid/ready handshake.
- Accepts redirects (branch/jump) from execute and discards any in-flight fetch made stale by one.

Parameters:
- ADDR_W, 24, width of the memory controller word address.
- XLEN, 32, PC and instruction width.
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  one-cycle pulse: load a new PC.
- redirect_pc  input  XLEN  new byte PC; bits [1:0] ignored (treated as 0).
- instr_valid  output  1  instr_data/instr_pc valid for decode.
- instr_ready  input  1  decode accepts when instr_valid && instr_ready.
- instr_data  output  XLEN  fetched instruction word.
- instr_pc  output  XLEN  byte PC of instr_data.
- mem_addr  output  ADDR_W  word address = pc[ADDR_W+1:2].
- mem_we  output  1  constant 0 (fetch is read-only).
- mem_data_in  output  32  constant 0.
- mem_enable  output  1  one-cycle start pulse to the memory controller.
- mem_data_out  input  32  read data; valid only in a cycle where mem_op_r=1.
- mem_op_r  input  1  read data ready.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE, discard=0.
  - mem_enable=0, instr_valid=0, instr_data=0, instr_pc=0, mem_addr=0.
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE: first clock after reset release -> REQ. No other entry.
  - REQ: mem_enable=1 for exactly this cycle; mem_addr=pc[ADDR_W+1:2] (registered, stable from REQ through WAIT). Next -> WAIT.
  - WAIT: mem_enable=0. On mem_op_r=1:
    - If discard=0: latch instr_data=mem_data_out and instr_pc=pc, set instr_valid=1 on the next edge, -> HOLD.
    - If discard=1: drop the data, clear discard, -> REQ (fetch the redirect PC).
  - HOLD: instr_valid=1; instr_data/instr_pc stable. On instr_valid && instr_ready: instr_valid=0 next cycle, pc<=pc+4, -> REQ.
- Throughput: one instruction per (REQ + memory latency + HOLD handshake). No prefetch; never more than one outstanding request.
- Redirect (redirect_valid=1); it has priority over every other PC update:
  - pc <= {redirect_pc[XLEN-1:2],2'b00} in all states.
  - In REQ or WAIT: discard<=1. If mem_op_r arrives in the same WAIT cycle as the redirect, that data is dropped and the state goes to REQ.
  - In HOLD: instr_valid<=0 next cycle even if instr_ready=1 in the same cycle; the held word is not consumed. -> REQ.
  - In IDLE: pc updated; -> REQ as normal.
  - Back-to-back redirects: the last one wins.
- PC arithmetic: modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0. mem_addr truncates pc to ADDR_W word bits.
- mem_enable is never asserted while a request is outstanding (WAIT) or in HOLD.
- Reset mid-transaction: all state cleared immediately. Any mem_op_r arriving after reset, before the next REQ, is ignored (state=IDLE).
- mem_op_r outside WAIT: ignored.

Decomposition:
- Shared package rv_pkg: XLEN, fetch state encoding (IDLE/REQ/WAIT/HOLD), RESET_PC default, NOP constant 32'h0000_0013.
- Single module; no sub-module is natural.
- The bench reuses memory_controller_module as the memory model.

Test Plan:
- Reset release with mem[0]=32'h0080016f, instr_ready=1 -> one mem_enable pulse with mem_addr=0; instr_valid=1, instr_data=32'h0080016f, instr_pc=0; next request has mem_addr=1.
- Sequential fetch, mem[0..3]=A,B,C,D, instr_ready=1 -> instr_pc sequence 0,4,8,12 with matching data; exactly one mem_enable per instruction.
- Backpressure: instr_ready=0 for 10 cycles in HOLD -> instr_data/instr_pc constant, no mem_enable; ready=1 -> accepted once, pc=4.
- Redirect during WAIT to 32'h0000_0008 -> stale data dropped (no instr_valid); next mem_addr=2; first delivered instr_pc=8.
- Redirect in HOLD with instr_ready=1 in the same cycle, redirect_pc=32'h0000_000E -> held word not consumed; instr_valid falls; next fetch at pc=0x0C, mem_addr=3.
- rst_n asserted in WAIT -> outputs zero immediately; the late mem_op_r is ignored; after release fetch restarts at RESET_PC.
